vec_mult_sched: RTL and testbench



---
 rtl/vec_mult_sched.sv | 134 +++++++++++++
 tb/tb_vec_mult_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mult_sched.sv
// vec_mult_sched
//
// Time-shares one external combinational multiplier across two packed operand
// vectors. On start both vectors are latched, then one element pair per cycle
// is presented to the multiplier (LSB element first). Products are shifted
// into the packed result vector, and their sum is accumulated as a dot product.
//
// Ports
//   clk     : single clock, rising edge
//   reset   : asynchronous, active-low
//   start   : request a vector operation (sampled only in IDLE)
//   A_in    : multiplier vector, element i at [i*Nbits +: Nbits]
//   B_in    : multiplicand vector, same packing
//   mult_a  : operand to the shared multiplier (0 outside RUN)
//   mult_b  : operand to the shared multiplier (0 outside RUN)
//   mult_p  : product from the shared multiplier, same cycle as mult_a/mult_b
//   busy    : high while elements are being multiplied
//   done    : one-cycle pulse, out/dot final
//   out     : packed products, element i at [i*2*Nbits +: 2*Nbits]
//   dot     : unsigned sum of all products
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; out/dot hold the last results
// RUN   | one element pair multiplied per cycle, idx = element index
// DONE  | results valid, done pulses for one cycle
module vec_mult_sched #(
    parameter int Nbits = 4,
    parameter int Ndata = 8,
    parameter int ACC_W = 2*Nbits + $clog2(Ndata)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [Ndata*Nbits-1:0]   A_in,
    input  logic [Ndata*Nbits-1:0]   B_in,
    output logic [Nbits-1:0]         mult_a,
    output logic [Nbits-1:0]         mult_b,
    input  logic [2*Nbits-1:0]       mult_p,
    output logic                     busy,
    output logic                     done,
    output logic [Ndata*2*Nbits-1:0] out,
    output logic [ACC_W-1:0]         dot
);

    localparam int IDX_W = $clog2(Ndata);
    localparam int PW    = 2*Nbits;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Ndata - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [Ndata*Nbits-1:0]   a_sh;
    logic [Ndata*Nbits-1:0]   b_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mult_a    = '0;
        mult_b    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                mult_a = a_sh[Nbits-1:0];
                mult_b = b_sh[Nbits-1:0];
                // Exact compare: Ndata need not be a power of two.
                if (idx == IDX_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            out  <= '0;
            dot  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= A_in;
                        b_sh <= B_in;
                        idx  <= '0;
                        out  <= '0;
                        dot  <= '0;
                    end
                end
                S_RUN: begin
                    // Products enter at the top; after Ndata shifts element 0
                    // has reached the bottom slot.
                    out  <= {mult_p, out[Ndata*PW-1:PW]};
                    dot  <= dot + ACC_W'(mult_p);
                    a_sh <= a_sh >> Nbits;
                    b_sh <= b_sh >> Nbits;
                    idx  <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mult_sched.sv
module tb_vec_mult_sched;

    localparam int NB = 4;
    localparam int ND = 8;
    localparam int AW = 2*NB + $clog2(ND);

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [ND*NB-1:0]     A_in;
    logic [ND*NB-1:0]     B_in;
    logic [NB-1:0]        mult_a;
    logic [NB-1:0]        mult_b;
    logic [2*NB-1:0]      mult_p;
    logic                 busy;
    logic                 done;
    logic [ND*2*NB-1:0]   out;
    logic [AW-1:0]        dot;

    vec_mult_sched #(.Nbits(NB), .Ndata(ND)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A_in   (A_in),
        .B_in   (B_in),
        .mult_a (mult_a),
        .mult_b (mult_b),
        .mult_p (mult_p),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .dot    (dot)
    );

    // Stand-in for the shared unsigned multiplier.
    assign mult_p = mult_a * mult_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ND*2*NB-1:0] out;
        logic [AW-1:0]      dot;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    logic [ND*2*NB-1:0] last_out = '0;
    logic [AW-1:0]      last_dot = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: element-wise products and their sum.
    function automatic exp_t model(input logic [ND*NB-1:0] a, input logic [ND*NB-1:0] b, input int dcyc);
        exp_t e;
        int   sum;
        int   p;
        sum   = 0;
        e.out = '0;
        for (int i = 0; i < ND; i++) begin
            p = int'(a[i*NB +: NB]) * int'(b[i*NB +: NB]);
            e.out[i*2*NB +: 2*NB] = (2*NB)'(p);
            sum += p;
        end
        e.dot = AW'(sum);
        e.cyc = dcyc;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_not_busy", {127'd0, busy}, 128'd0);
            check("busy_len", 128'(busy_cnt), 128'(ND));
            if (q.size() == 0) begin
                check("spurious_done", 128'd1, 128'd0);
            end else begin
                e = q.pop_front();
                check("out", 128'(out), 128'(e.out));
                check("dot", 128'(dot), 128'(e.dot));
                check("done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
        if (busy) busy_cnt++;
        else      busy_cnt = 0;
    end

    task automatic issue(input logic [ND*NB-1:0] a, input logic [ND*NB-1:0] b);
        exp_t e;
        @(negedge clk);
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(a, b, cyc + ND);
        q.push_back(e);
        last_out = e.out;
        last_dot = e.dot;
        A_in = $urandom;
        B_in = $urandom;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 80; t++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", 128'(q.size()), 128'd0);
        q.delete();
        @(negedge clk);
    endtask

    localparam logic [31:0] NOM_A = 32'h76543210;
    localparam logic [31:0] NOM_B = 32'h01234567;

    initial begin
        exp_t e;
        reset = 1'b0;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_mult", 128'({mult_a, mult_b}), 128'd0);
        check("rst_out", 128'(out), 128'd0);
        check("rst_dot", 128'(dot), 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // Nominal and saturation.
        issue(NOM_A, NOM_B);
        wait_idle();
        check("nom_out_const", 128'(out), 128'h00060a0c0c0a0600);
        check("nom_dot_const", 128'(dot), 128'd56);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        check("sat_out_const", 128'(out), 128'he1e1e1e1e1e1e1e1);
        check("sat_dot_const", 128'(dot), 128'd1800);

        // Random vectors.
        for (int r = 0; r < 8; r++) begin
            issue($urandom, $urandom);
            wait_idle();
        end

        // Start while busy is ignored.
        issue(NOM_A, NOM_B);
        repeat (3) @(negedge clk);
        A_in  = $urandom;
        B_in  = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (ND + 4) @(negedge clk);

        // Back-to-back with start held high.
        @(negedge clk);
        A_in  = NOM_A;
        B_in  = NOM_B;
        start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(NOM_A, NOM_B, cyc + ND));
        A_in = 32'h11111111;
        B_in = 32'h11111111;
        repeat (ND + 2) @(posedge clk);
        #1;
        e = model(32'h11111111, 32'h11111111, cyc + ND);
        q.push_back(e);
        start = 1'b0;
        A_in  = $urandom;
        B_in  = $urandom;
        wait_idle();
        check("b2b_dot_const", 128'(dot), 128'd8);
        check("b2b_out_const", 128'(out), 128'h0101010101010101);
        last_out = e.out;
        last_dot = e.dot;

        // Idle quiet with toggling inputs.
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            A_in = $urandom;
            B_in = $urandom;
            #1;
            check("idle_quiet", 128'({mult_a, mult_b, busy, done}), 128'd0);
            check("idle_hold", 128'({out, dot}), 128'({last_out, last_dot}));
        end

        // Reset mid-operation at idx 4.
        issue(NOM_A, NOM_B);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ctl", 128'({mult_a, mult_b, busy, done}), 128'd0);
        check("midrst_res", 128'({out, dot}), 128'd0);
        q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (ND + 4) @(negedge clk);
        check("midrst_hold", 128'({out, dot, busy, done}), 128'd0);
        issue(NOM_A, NOM_B);
        wait_idle();
        check("post_rst_dot", 128'(dot), 128'd56);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
